// File: rtl/prra_lut_block.sv
// prra_lut_block: single-pointer round-robin next-owner lookup.
//
// Each instance is built for one fixed round-robin pointer (STATE_OFFSET).
// It scans the request vector starting just after that pointer, wrapping
// around, with the pointer position itself scanned last, and reports the
// first requesting index. There is no pointer state inside the block; the
// result depends only on the request vector and STATE_OFFSET.
//
// Configuration macro:
//   PRRA_LUT_OUTREG_EN  defined   : state/valid registered on clk, one-cycle
//                                   latency, synchronous active-high srst
//                                   clears both outputs.
//                       undefined : state/valid purely combinational; clk and
//                                   srst are present but unused.
//
// Parameters:
//   WIDTH         number of requesters (>= 2)
//   LOG2_WIDTH    width of the state output (2**LOG2_WIDTH >= WIDTH)
//   STATE_OFFSET  pointer this instance is built for (0 .. WIDTH-1)
//
// Ports:
//   clk      in   clock, rising edge (registered build only)
//   srst     in   synchronous active-high reset (registered build only)
//   request  in   [WIDTH]       bit k set => requester k is requesting
//   state    out  [LOG2_WIDTH]  index of the next requester to grant
//   valid    out  high when any request bit is set

module prra_lut_block #(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned LOG2_WIDTH   = 2,
  parameter int unsigned STATE_OFFSET = 0
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic [WIDTH-1:0]      request,
  output logic [LOG2_WIDTH-1:0] state,
  output logic                  valid
);

  // Request vector rotated so that bit 0 is the first index to scan
  // ((STATE_OFFSET+1) mod WIDTH) and bit WIDTH-1 is STATE_OFFSET itself.
  logic [WIDTH-1:0]      rot_req;
  logic [LOG2_WIDTH-1:0] sel_c;
  logic                  any_c;

  always_comb begin
    rot_req = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      rot_req[i] = request[(STATE_OFFSET + 1 + i) % WIDTH];
    end
  end

  // Parallel priority pick over the rotated vector. Walking from the top
  // down lets the lowest set rotated bit win. With no request the default
  // leaves the pointer itself as the answer.
  always_comb begin
    sel_c = LOG2_WIDTH'(STATE_OFFSET);
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (rot_req[i]) begin
        sel_c = LOG2_WIDTH'((STATE_OFFSET + 1 + int'(unsigned'(i))) % WIDTH);
      end
    end
  end

  assign any_c = |request;

`ifdef PRRA_LUT_OUTREG_EN

  logic [LOG2_WIDTH-1:0] state_q;
  logic                  valid_q;

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= sel_c;
      valid_q <= any_c;
    end
  end

  assign state = state_q;
  assign valid = valid_q;

`else

  // Clock and reset are kept on the port list so both builds share one
  // footprint; fold them into a sink so they are visibly intentional.
  logic unused_clk_srst;
  assign unused_clk_srst = clk ^ srst;

  assign state = sel_c;
  assign valid = any_c;

`endif

endmodule

// File: tb/tb_prra_lut_block.sv
// Bench for prra_lut_block: four instances (STATE_OFFSET 0..3, WIDTH=4) share
// one request bus and are checked against a round-robin scan model. Works for
// both the combinational and the PRRA_LUT_OUTREG_EN build.

module tb_prra_lut_block;

  localparam int NumOff = 4;

  logic       clk;
  logic       srst;
  logic [3:0] request;
  logic [1:0] st [NumOff];
  logic       vl [NumOff];

  int n_cmp;
  int n_err;

  for (genvar g = 0; g < NumOff; g++) begin : g_dut
    prra_lut_block #(
      .WIDTH       (4),
      .LOG2_WIDTH  (2),
      .STATE_OFFSET(g)
    ) u_dut (
      .clk    (clk),
      .srst   (srst),
      .request(request),
      .state  (st[g]),
      .valid  (vl[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: walk the requesters in round-robin order after the pointer.
  function automatic logic [1:0] ref_state(input int off, input logic [3:0] r);
    int idx;
    for (int k = 1; k <= 4; k++) begin
      idx = (off + k) % 4;
      if (r[idx]) return 2'(idx);
    end
    return 2'(off);
  endfunction

  function automatic logic ref_valid(input logic [3:0] r);
    return r != 4'b0000;
  endfunction

  // Drive a request just after an edge and wait until the result is visible.
  task automatic apply(input logic [3:0] r, input logic rst);
    @(posedge clk);
    #1;
    request = r;
    srst    = rst;
`ifdef PRRA_LUT_OUTREG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  task automatic test_reset();
    logic [3:0] r;
`ifdef PRRA_LUT_OUTREG_EN
    // srst wins over a live request on the same edge.
    for (int n = 0; n < 6; n++) begin
      r = (n == 0) ? 4'b1001 : 4'($urandom_range(1, 15));
      apply(r, 1'b1);
      for (int o = 0; o < NumOff; o++) begin
        n_cmp++;
        if (st[o] !== 2'd0 || vl[o] !== 1'b0) begin
          n_err++;
          $display("FAIL reset off=%0d req=%b got state=%0d valid=%b want state=0 valid=0",
                   o, r, st[o], vl[o]);
        end
      end
    end
`else
    // srst has no effect: outputs track request.
    for (int n = 0; n < 6; n++) begin
      r = (n == 0) ? 4'b1001 : 4'($urandom_range(0, 15));
      apply(r, 1'b1);
      for (int o = 0; o < NumOff; o++) begin
        n_cmp++;
        if (st[o] !== ref_state(o, r) || vl[o] !== ref_valid(r)) begin
          n_err++;
          $display("FAIL reset_noeffect off=%0d req=%b got state=%0d valid=%b want %0d/%b",
                   o, r, st[o], vl[o], ref_state(o, r), ref_valid(r));
        end
      end
    end
`endif
  endtask

  task automatic test_directed();
    int         off_t [5];
    logic [3:0] req_t [5];
    logic [1:0] st_t  [5];
    logic       vl_t  [5];
    off_t = '{0, 2, 2, 3, 1};
    req_t = '{4'b0110, 4'b0011, 4'b0100, 4'b0000, 4'b1111};
    st_t  = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd2};
    vl_t  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int n = 0; n < 5; n++) begin
      apply(req_t[n], 1'b0);
      n_cmp++;
      if (st[off_t[n]] !== st_t[n] || vl[off_t[n]] !== vl_t[n]) begin
        n_err++;
        $display("FAIL directed off=%0d req=%b got state=%0d valid=%b want %0d/%b",
                 off_t[n], req_t[n], st[off_t[n]], vl[off_t[n]], st_t[n], vl_t[n]);
      end
    end
  endtask

  task automatic test_exhaustive();
    logic [3:0] r;
    for (int v = 0; v < 16; v++) begin
      r = 4'(v);
      apply(r, 1'b0);
      for (int o = 0; o < NumOff; o++) begin
        n_cmp++;
        if (st[o] !== ref_state(o, r) || vl[o] !== ref_valid(r)) begin
          n_err++;
          $display("FAIL exhaustive off=%0d req=%b got state=%0d valid=%b want %0d/%b",
                   o, r, st[o], vl[o], ref_state(o, r), ref_valid(r));
        end
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    for (int n = 0; n < 200; n++) begin
      r = 4'($urandom);
      apply(r, 1'b0);
      for (int o = 0; o < NumOff; o++) begin
        n_cmp++;
        if (st[o] !== ref_state(o, r) || vl[o] !== ref_valid(r)) begin
          n_err++;
          $display("FAIL random off=%0d req=%b got state=%0d valid=%b want %0d/%b",
                   o, r, st[o], vl[o], ref_state(o, r), ref_valid(r));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
`ifdef PRRA_LUT_OUTREG_EN
    logic [3:0] prev;
    logic [3:0] r;
    // Reset with 1001 held, release, then switch to 0001 (offset 1).
    apply(4'b1001, 1'b1);
    n_cmp++;
    if (st[1] !== 2'd0 || vl[1] !== 1'b0) begin
      n_err++;
      $display("FAIL seq_reset got state=%0d valid=%b want 0/0", st[1], vl[1]);
    end
    apply(4'b1001, 1'b0);
    n_cmp++;
    if (st[1] !== 2'd3 || vl[1] !== 1'b1) begin
      n_err++;
      $display("FAIL seq_release got state=%0d valid=%b want 3/1", st[1], vl[1]);
    end
    apply(4'b0001, 1'b0);
    n_cmp++;
    if (st[1] !== 2'd0 || vl[1] !== 1'b1) begin
      n_err++;
      $display("FAIL seq_change got state=%0d valid=%b want 0/1", st[1], vl[1]);
    end
    // Latency is exactly one edge: before the edge the old result holds.
    prev = 4'b0001;
    for (int n = 0; n < 20; n++) begin
      r = 4'($urandom);
      @(posedge clk);
      #1;
      request = r;
      #2;
      for (int o = 0; o < NumOff; o++) begin
        n_cmp++;
        if (st[o] !== ref_state(o, prev) || vl[o] !== ref_valid(prev)) begin
          n_err++;
          $display("FAIL latency_hold off=%0d req=%b got state=%0d valid=%b want %0d/%b",
                   o, r, st[o], vl[o], ref_state(o, prev), ref_valid(prev));
        end
      end
      @(posedge clk);
      #1;
      for (int o = 0; o < NumOff; o++) begin
        n_cmp++;
        if (st[o] !== ref_state(o, r) || vl[o] !== ref_valid(r)) begin
          n_err++;
          $display("FAIL latency_load off=%0d req=%b got state=%0d valid=%b want %0d/%b",
                   o, r, st[o], vl[o], ref_state(o, r), ref_valid(r));
        end
      end
      prev = r;
    end
`else
    logic [3:0] r;
    // Zero latency: outputs follow a change within the same cycle.
    for (int n = 0; n < 20; n++) begin
      r = 4'($urandom);
      #1;
      request = r;
      #1;
      for (int o = 0; o < NumOff; o++) begin
        n_cmp++;
        if (st[o] !== ref_state(o, r) || vl[o] !== ref_valid(r)) begin
          n_err++;
          $display("FAIL comb_follow off=%0d req=%b got state=%0d valid=%b want %0d/%b",
                   o, r, st[o], vl[o], ref_state(o, r), ref_valid(r));
        end
      end
    end
`endif
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    srst    = 1'b1;
    request = 4'b0000;
    test_reset();
    test_directed();
    test_exhaustive();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
